// File: rtl/ethernet_decapsulation_pkg.sv
// Shared framing constants and the byte-wide Ethernet CRC-32 step used on both sides of the link.
package ethernet_decapsulation_pkg;

  localparam logic [7:0]  preamble_val    = 8'h2A;
  localparam logic [7:0]  sfd_val         = 8'h2B;
  localparam int          len_addr        = 6;
  localparam int          len_len         = 2;
  localparam int          len_crc         = 4;
  localparam int          min_payload_len = 46;
  localparam logic [31:0] crc32_poly      = 32'hEDB88320;
  localparam logic [31:0] crc32_init      = 32'hFFFFFFFF;

  // Reflected CRC-32, one byte LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ crc32_poly) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/ethernet_decapsulation_crc32_comb.sv
// Combinational CRC-32 next-value: reload on active-high rst, advance one byte when en, else hold.
module crc32_comb
  import ethernet_decapsulation_pkg::*;
(
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  always_comb begin
    if (rst)
      crc_out = crc32_init;
    else if (en)
      crc_out = crc32_byte(crc_in, data);
    else
      crc_out = crc_in;
  end

endmodule

// File: rtl/ethernet_decapsulation.sv
// GMII receive deframer: strips preamble/SFD, filters destination, forwards payload, checks FCS.
// Payload and status are registered one cycle after the byte is sampled; no backpressure.
module ethernet_decapsulation
  import ethernet_decapsulation_pkg::*;
#(
  parameter logic [47:0] local_mac_addr   = 48'h023528fbdd66,
  parameter bit          accept_broadcast = 1'b1,
  parameter int          max_payload_len  = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic [47:0] src_mac,
  output logic [15:0] len_field,
  output logic        frame_done,
  output logic        frame_good,
  output logic        err_crc,
  output logic        err_addr,
  output logic        err_len,
  output logic        err_trunc
);

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD, FCS, DROP
  } state_t;

  localparam logic [15:0] max_len   = 16'(max_payload_len);
  localparam logic [15:0] min_len   = 16'(min_payload_len);
  localparam logic [10:0] addr_last = 11'(len_addr - 1);
  localparam logic [10:0] len_last  = 11'(len_len - 1);
  localparam logic [10:0] crc_last  = 11'(len_crc - 1);
  localparam logic [10:0] pad_last  = 11'(min_payload_len - 1);

  state_t      state;
  logic        armed;
  logic [10:0] cnt;
  logic [39:0] dest;
  logic [23:0] fcs;
  logic [31:0] crc, crc_next;
  logic        crc_rst, crc_en, in_frame, dest_ok;
  logic [47:0] dest_nxt;
  logic [15:0] len_nxt;
  logic [31:0] fcs_nxt;

  assign in_frame = state inside {DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD, FCS};
  assign crc_rst  = !rst || (state inside {IDLE, PREAMBLE, DROP});
  assign crc_en   = gmii_rx_dv && !gmii_rx_er && (state inside {DEST_MAC, SRC_MAC, LEN, PAYLOAD, PAD});
  assign dest_nxt = {dest, gmii_rxd};
  assign len_nxt  = {len_field[7:0], gmii_rxd};
  assign fcs_nxt  = {fcs, gmii_rxd};
  assign dest_ok  = (dest_nxt == local_mac_addr) ||
                    (accept_broadcast && (dest_nxt == {48{1'b1}}));

  crc32_comb u_crc (
    .rst     (crc_rst),
    .en      (crc_en),
    .data    (gmii_rxd),
    .crc_in  (crc),
    .crc_out (crc_next)
  );

  // FCS bytes never advance the CRC, so the value held here is the latched result.
  always_ff @(posedge clk) crc <= crc_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      armed         <= 1'b0;
      cnt           <= '0;
      dest          <= '0;
      fcs           <= '0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      src_mac       <= '0;
      len_field     <= '0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      err_crc       <= 1'b0;
      err_addr      <= 1'b0;
      err_len       <= 1'b0;
      err_trunc     <= 1'b0;
    end else begin
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      frame_done    <= 1'b0;
      frame_good    <= 1'b0;
      err_crc       <= 1'b0;
      err_addr      <= 1'b0;
      err_len       <= 1'b0;
      err_trunc     <= 1'b0;
      if (!gmii_rx_dv)
        armed <= 1'b1;

      if (in_frame && (!gmii_rx_dv || gmii_rx_er)) begin
        frame_done <= 1'b1;
        err_trunc  <= 1'b1;
        state      <= gmii_rx_dv ? DROP : IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (armed && gmii_rx_dv && (gmii_rxd == preamble_val))
              state <= PREAMBLE;
          end
          PREAMBLE: begin
            cnt <= '0;
            if (!gmii_rx_dv)
              state <= IDLE;
            else if (gmii_rx_er)
              state <= DROP;
            else if (gmii_rxd == sfd_val)
              state <= DEST_MAC;
            else if (gmii_rxd != preamble_val)
              state <= DROP;
          end
          DEST_MAC: begin
            dest <= dest_nxt[39:0];
            cnt  <= cnt + 11'd1;
            if (cnt == addr_last) begin
              cnt <= '0;
              if (dest_ok) begin
                state <= SRC_MAC;
              end else begin
                frame_done <= 1'b1;
                err_addr   <= 1'b1;
                state      <= DROP;
              end
            end
          end
          SRC_MAC: begin
            src_mac <= {src_mac[39:0], gmii_rxd};
            cnt     <= cnt + 11'd1;
            if (cnt == addr_last) begin
              cnt   <= '0;
              state <= LEN;
            end
          end
          LEN: begin
            len_field <= len_nxt;
            cnt       <= cnt + 11'd1;
            if (cnt == len_last) begin
              cnt <= '0;
              if ((len_nxt == 16'd0) || (len_nxt > max_len)) begin
                frame_done <= 1'b1;
                err_len    <= 1'b1;
                state      <= DROP;
              end else begin
                state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            payload_valid <= 1'b1;
            payload_data  <= gmii_rxd;
            cnt           <= cnt + 11'd1;
            if ({5'd0, cnt} == len_field - 16'd1) begin
              payload_last <= 1'b1;
              // Short frames keep counting through PAD until 46 body bytes are consumed.
              if (len_field < min_len) begin
                state <= PAD;
              end else begin
                cnt   <= '0;
                state <= FCS;
              end
            end
          end
          PAD: begin
            cnt <= cnt + 11'd1;
            if (cnt == pad_last) begin
              cnt   <= '0;
              state <= FCS;
            end
          end
          FCS: begin
            fcs <= fcs_nxt[23:0];
            cnt <= cnt + 11'd1;
            if (cnt == crc_last) begin
              frame_done <= 1'b1;
              frame_good <= (fcs_nxt == ~crc);
              err_crc    <= (fcs_nxt != ~crc);
              state      <= DROP;
            end
          end
          DROP: begin
            if (!gmii_rx_dv)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ethernet_decapsulation.sv
// Randomized and directed frames scored against a frame-level reference model.
module tb_ethernet_decapsulation;

  typedef logic [7:0] bq_t[$];

  localparam logic [47:0] LOCAL  = 48'h023528fbdd66;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam int          MAXLEN = 1500;
  localparam int          MINLEN = 46;
  localparam logic [4:0]  ST_GOOD = 5'b10000, ST_CRC = 5'b01000, ST_ADDR = 5'b00100,
                          ST_LEN  = 5'b00010, ST_TRUNC = 5'b00001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic [7:0]  payload_data;
  logic        payload_valid, payload_last;
  logic [47:0] src_mac;
  logic [15:0] len_field;
  logic        frame_done, frame_good, err_crc, err_addr, err_len, err_trunc;

  ethernet_decapsulation dut (
    .clk(clk), .rst(rst), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .payload_data(payload_data), .payload_valid(payload_valid), .payload_last(payload_last),
    .src_mac(src_mac), .len_field(len_field), .frame_done(frame_done), .frame_good(frame_good),
    .err_crc(err_crc), .err_addr(err_addr), .err_len(err_len), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_bad = 0;
  logic [31:0] crc_tab [256];

  logic [8:0]  obs_beat_q[$], exp_beat_q[$];
  int          obs_bcyc_q[$], exp_bcyc_q[$];
  logic [4:0]  obs_st_q[$],   exp_st_q[$];
  int          obs_cyc_q[$],  exp_cyc_q[$];
  logic [47:0] obs_src_q[$],  exp_src_q[$];
  logic [15:0] obs_len_q[$],  exp_len_q[$];
  bit          exp_hdr_q[$];

  always @(negedge clk) begin
    if (payload_valid) begin
      obs_beat_q.push_back({payload_last, payload_data});
      obs_bcyc_q.push_back(cyc);
    end
    if (frame_done) begin
      obs_st_q.push_back({frame_good, err_crc, err_addr, err_len, err_trunc});
      obs_cyc_q.push_back(cyc);
      obs_src_q.push_back(src_mac);
      obs_len_q.push_back(len_field);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fcs_of(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ b[i]];
    return ~c;
  endfunction

  function automatic bq_t rand_pay(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  function automatic bq_t mk_body(input logic [47:0] dest, input logic [47:0] src,
                                  input logic [15:0] len, input bq_t pay, input bit flip);
    bq_t b;
    logic [31:0] f;
    for (int i = 5; i >= 0; i--) b.push_back(dest[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(src[i*8 +: 8]);
    b.push_back(len[15:8]);
    b.push_back(len[7:0]);
    foreach (pay[i]) b.push_back(pay[i]);
    for (int i = pay.size(); i < MINLEN; i++) b.push_back(8'h00);
    f = fcs_of(b);
    if (flip) f[0] = ~f[0];
    for (int i = 3; i >= 0; i--) b.push_back(f[i*8 +: 8]);
    return b;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
  endtask

  // Sends preamble, SFD and the first nsent body bytes, then drops dv; records the expected outcome.
  task automatic send_frame(input bq_t body, input bq_t pay, input logic [47:0] dest,
                            input logic [47:0] src, input int len, input int nsent, input bit flip);
    int dc[$];
    int dec, nb, bend;
    logic [4:0] st;
    bit lastb, hdr;
    repeat (7) drive(1'b1, 8'h2A);
    drive(1'b1, 8'h2B);
    for (int i = 0; i < nsent; i++) begin
      drive(1'b1, body[i]);
      dc.push_back(cyc);
    end
    drive(1'b0, 8'h00);
    dc.push_back(cyc);

    nb = 0; lastb = 1'b0; hdr = 1'b0; dec = nsent; st = ST_TRUNC;
    if (nsent >= 6 && !(dest == LOCAL || dest == BCAST)) begin
      dec = 5; st = ST_ADDR;
    end else if (nsent >= 14) begin
      hdr = 1'b1;
      if (len == 0 || len > MAXLEN) begin
        dec = 13; st = ST_LEN;
      end else begin
        nb    = (nsent - 14 < len) ? nsent - 14 : len;
        lastb = (nsent >= 14 + len);
        bend  = 14 + ((len < MINLEN) ? MINLEN : len);
        if (nsent >= bend + 4) begin
          dec = bend + 3;
          st  = flip ? ST_CRC : ST_GOOD;
        end
      end
    end
    for (int i = 0; i < nb; i++) begin
      exp_beat_q.push_back({(lastb && (i == nb - 1)), pay[i]});
      exp_bcyc_q.push_back(dc[14 + i] + 1);
    end
    exp_st_q.push_back(st);
    exp_cyc_q.push_back(dc[dec] + 1);
    exp_hdr_q.push_back(hdr);
    exp_src_q.push_back(src);
    exp_len_q.push_back(16'(len));
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("beat_count", obs_beat_q.size(), exp_beat_q.size());
    for (int i = 0; i < exp_beat_q.size() && i < obs_beat_q.size(); i++) begin
      chk("beat_last_data", obs_beat_q[i], exp_beat_q[i]);
      chk("beat_cycle", obs_bcyc_q[i], exp_bcyc_q[i]);
    end
    chk("status_count", obs_st_q.size(), exp_st_q.size());
    for (int i = 0; i < exp_st_q.size() && i < obs_st_q.size(); i++) begin
      chk("status_good_crc_addr_len_trunc", obs_st_q[i], exp_st_q[i]);
      chk("status_cycle", obs_cyc_q[i], exp_cyc_q[i]);
      if (exp_hdr_q[i]) begin
        chk("src_mac", obs_src_q[i], exp_src_q[i]);
        chk("len_field", obs_len_q[i], exp_len_q[i]);
      end
    end
    obs_beat_q.delete(); obs_bcyc_q.delete(); obs_st_q.delete(); obs_cyc_q.delete();
    obs_src_q.delete(); obs_len_q.delete();
    exp_beat_q.delete(); exp_bcyc_q.delete(); exp_st_q.delete(); exp_cyc_q.delete();
    exp_src_q.delete(); exp_len_q.delete(); exp_hdr_q.delete();
  endtask

  initial begin
    bq_t pay, body, pay2, body2;
    logic [47:0] src;
    logic [31:0] c;

    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[i] = c;
    end

    // Reset values
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_payload_valid", payload_valid, 1'b0);
    chk("rst_payload_last", payload_last, 1'b0);
    chk("rst_payload_data", payload_data, 8'h00);
    chk("rst_src_mac", src_mac, 48'h0);
    chk("rst_len_field", len_field, 16'h0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_flags", {frame_good, err_crc, err_addr, err_len, err_trunc}, 5'b0);
    rst = 1'b1;
    drive(1'b0, 8'h00);

    // Good frame, 4-byte payload with 42 pad bytes
    src = 48'h0A0B0C0D0E0F;
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    body = mk_body(LOCAL, src, 16'd4, pay, 1'b0);
    send_frame(body, pay, LOCAL, src, 4, body.size(), 1'b0);
    drain();

    // Same frame, FCS bit 0 flipped
    body = mk_body(LOCAL, src, 16'd4, pay, 1'b1);
    send_frame(body, pay, LOCAL, src, 4, body.size(), 1'b1);
    drain();

    // Wrong destination
    body = mk_body(48'h023528fbdd67, src, 16'd4, pay, 1'b0);
    send_frame(body, pay, 48'h023528fbdd67, src, 4, body.size(), 1'b0);
    drain();

    // Oversize length field
    pay2 = rand_pay(8);
    body = mk_body(LOCAL, src, 16'd1501, pay2, 1'b0);
    send_frame(body, pay2, LOCAL, src, 1501, body.size(), 1'b0);
    drain();

    // Broadcast, exactly minimum length (no pad)
    pay2 = rand_pay(46);
    body = mk_body(BCAST, src, 16'd46, pay2, 1'b0);
    send_frame(body, pay2, BCAST, src, 46, body.size(), 1'b0);
    drain();

    // Truncated after 2 payload bytes, then a good frame straight after
    body = mk_body(LOCAL, src, 16'd4, pay, 1'b0);
    send_frame(body, pay, LOCAL, src, 4, 16, 1'b0);
    pay2 = rand_pay(10);
    body2 = mk_body(LOCAL, 48'h112233445566, 16'd10, pay2, 1'b0);
    send_frame(body2, pay2, LOCAL, 48'h112233445566, 10, body2.size(), 1'b0);
    drain();

    // Reset during SRC_MAC, released with dv still high; payload mimics a preamble
    pay2 = '{8'h2A, 8'h2A, 8'h2A, 8'h2B, 8'h02, 8'h35, 8'h28, 8'hFB, 8'hDD, 8'h66};
    body = mk_body(LOCAL, src, 16'd10, pay2, 1'b0);
    repeat (7) drive(1'b1, 8'h2A);
    drive(1'b1, 8'h2B);
    for (int i = 0; i < 9; i++) drive(1'b1, body[i]);
    @(posedge clk); #1; rst = 1'b0; gmii_rxd = body[9];
    @(posedge clk); #1; gmii_rxd = body[10];
    chk("midrst_src_mac", src_mac, 48'h0);
    chk("midrst_len_field", len_field, 16'h0);
    chk("midrst_valid_done", {payload_valid, frame_done}, 2'b00);
    @(posedge clk); #1; rst = 1'b1; gmii_rxd = body[11];
    for (int i = 12; i < body.size(); i++) drive(1'b1, body[i]);
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h2A);
    drive(1'b0, 8'h00);
    drain();
    pay2 = rand_pay(20);
    body = mk_body(LOCAL, src, 16'd20, pay2, 1'b0);
    send_frame(body, pay2, LOCAL, src, 20, body.size(), 1'b0);
    drain();

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      int len, npay, nsent, r;
      logic [47:0] d, s;
      bit flip;
      r = int'($urandom_range(0, 7));
      d = (r == 0) ? {16'($urandom), 32'($urandom)} : ((r == 1) ? BCAST : LOCAL);
      s = {16'($urandom), 32'($urandom)};
      len = int'($urandom_range(1, 70));
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 1) ? 0 : 1501 + int'($urandom_range(0, 100));
      npay = (len == 0 || len > MAXLEN) ? 8 : len;
      pay2 = rand_pay(npay);
      flip = ($urandom_range(0, 3) == 0);
      body = mk_body(d, s, 16'(len), pay2, flip);
      nsent = body.size();
      if ($urandom_range(0, 4) == 0)
        nsent = int'($urandom_range(0, 13 + ((len == 0 || len > MAXLEN) ? 0 : len)));
      send_frame(body, pay2, d, s, len, nsent, flip);
      repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00);
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
